// File: rtl/fetch_sequencer.sv
// Two-cycle byte-wise instruction fetch sequencer: owns the PC, strobes the IR
// low/high halves, then holds the instruction valid until the execute stage finishes.
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  halt_i,
  input  logic                  exec_done_i,
  input  logic                  load_pc_i,
  input  logic [ADDR_WIDTH-1:0] new_pc_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_read_o,
  output logic                  ir_write_o,
  output logic                  ir_lh_o,
  output logic                  instr_valid_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [15:0]           fetch_count_o,
  output logic                  halted_o,
  output logic [1:0]            state_o
);

  localparam logic [1:0] FETCH_L = 2'd0;
  localparam logic [1:0] FETCH_H = 2'd1;
  localparam logic [1:0] ISSUE   = 2'd2;
  localparam logic [1:0] HALTED  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           fetch_count_q, fetch_count_d;
  logic                  fetching;
  logic                  new_pc_lsb_unused;

  // Branch targets are halfword aligned, so the LSB of new_pc_i never reaches the PC.
  assign new_pc_lsb_unused = new_pc_i[0];

  // Handshake: instr_valid_o acts as valid, exec_done_i as ready; an instruction is
  // retired on the first unstalled edge in ISSUE where both are high.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (!stall_i) begin
      case (state_q)
        FETCH_L: begin
          pc_d    = pc_q + PC_STEP;
          state_d = FETCH_H;
        end
        FETCH_H: begin
          pc_d          = pc_q + PC_STEP;
          fetch_count_d = fetch_count_q + 16'd1;
          state_d       = ISSUE;
        end
        ISSUE: begin
          if (exec_done_i) begin
            if (halt_i) begin
              state_d = HALTED;
            end else begin
              if (load_pc_i) pc_d = {new_pc_i[ADDR_WIDTH-1:1], 1'b0};
              state_d = FETCH_L;
            end
          end
        end
        default: state_d = HALTED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= FETCH_L;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Strobes come from registered state only; stall_i is the sole gating input.
  assign fetching      = (state_q == FETCH_L) || (state_q == FETCH_H);
  assign mem_read_o    = fetching && !stall_i;
  assign ir_write_o    = fetching && !stall_i;
  assign ir_lh_o       = (state_q == FETCH_H);
  assign instr_valid_o = (state_q == ISSUE);
  assign halted_o      = (state_q == HALTED);
  assign mem_addr_o    = pc_q;
  assign pc_o          = pc_q;
  assign fetch_count_o = fetch_count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each driven cycle queues its hand-computed
// observation, and a negedge monitor pops and compares it against the DUT.
module tb_fetch_sequencer;

  localparam int W = 39;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        halt;
  logic        exec_done;
  logic        load_pc;
  logic [15:0] new_pc;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        ir_write;
  logic        ir_lh;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] fetch_count;
  logic        halted;
  logic [1:0]  state;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;
  int cyc_idx;

  fetch_sequencer #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .halt_i(halt),
    .exec_done_i(exec_done), .load_pc_i(load_pc), .new_pc_i(new_pc),
    .mem_addr_o(mem_addr), .mem_read_o(mem_read), .ir_write_o(ir_write),
    .ir_lh_o(ir_lh), .instr_valid_o(instr_valid), .pc_o(pc),
    .fetch_count_o(fetch_count), .halted_o(halted), .state_o(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] pk(input logic [1:0] st, input logic rd,
      input logic wr, input logic lh, input logic iv, input logic h,
      input logic [15:0] p, input logic [15:0] fc);
    return {st, rd, wr, lh, iv, h, p, fc};
  endfunction

  // driver: one call per clock cycle, inputs applied 1 time unit after the edge
  task automatic cyc(input logic rst, input logic mid_rst, input logic st_i,
      input logic ex, input logic hl, input logic ld, input logic [15:0] np,
      input logic [W-1:0] exp_v);
    @(posedge clk);
    #1;
    rst_n     = rst;
    stall     = st_i;
    exec_done = ex;
    halt      = hl;
    load_pc   = ld;
    new_pc    = np;
    exp_q.push_back(exp_v);
    if (mid_rst) begin
      #2;
      rst_n = 1'b0;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, mem_read, ir_write, ir_lh, instr_valid, halted, pc, fetch_count};
      checks = checks + 1;
      if (a !== e || mem_addr !== e[31:16]) begin
        errors = errors + 1;
        $display("FAIL cyc%0d: got st=%0d rd=%b wr=%b lh=%b iv=%b h=%b pc=%h addr=%h fc=%h, expected st=%0d rd=%b wr=%b lh=%b iv=%b h=%b pc=%h fc=%h",
                 cyc_idx, a[38:37], a[36], a[35], a[34], a[33], a[32], a[31:16], mem_addr, a[15:0],
                 e[38:37], e[36], e[35], e[34], e[33], e[32], e[31:16], e[15:0]);
      end
      cyc_idx = cyc_idx + 1;
    end
  end

  initial begin
    checks = 0; errors = 0; cyc_idx = 0;
    rst_n = 1'b0; stall = 1'b0; halt = 1'b0; exec_done = 1'b0;
    load_pc = 1'b0; new_pc = 16'h0000;

    // reset, then back-to-back instructions with exec_done held high
    cyc(0,0,0,0,0,0,16'h0000, pk(2'd0,1,1,0,0,0,16'h0000,16'd0));
    cyc(1,0,0,1,0,0,16'h0000, pk(2'd0,1,1,0,0,0,16'h0000,16'd0));
    cyc(1,0,0,1,0,0,16'h0000, pk(2'd1,1,1,1,0,0,16'h0001,16'd0));
    cyc(1,0,0,1,0,0,16'h0000, pk(2'd2,0,0,0,1,0,16'h0002,16'd1));
    cyc(1,0,0,1,0,0,16'h0000, pk(2'd0,1,1,0,0,0,16'h0002,16'd1));
    cyc(1,0,0,1,0,0,16'h0000, pk(2'd1,1,1,1,0,0,16'h0003,16'd1));
    // branch to 0x0041 lands on 0x0040
    cyc(1,0,0,1,0,1,16'h0041, pk(2'd2,0,0,0,1,0,16'h0004,16'd2));
    cyc(1,0,0,0,0,0,16'h0000, pk(2'd0,1,1,0,0,0,16'h0040,16'd2));
    // three stalled cycles in FETCH_H, then the high byte is re-issued
    cyc(1,0,1,0,0,0,16'h0000, pk(2'd1,0,0,1,0,0,16'h0041,16'd2));
    cyc(1,0,1,0,0,0,16'h0000, pk(2'd1,0,0,1,0,0,16'h0041,16'd2));
    cyc(1,0,1,0,0,0,16'h0000, pk(2'd1,0,0,1,0,0,16'h0041,16'd2));
    cyc(1,0,0,0,0,0,16'h0000, pk(2'd1,1,1,1,0,0,16'h0041,16'd2));
    // stall beats exec_done in ISSUE; then branch to 0xFFFF -> 0xFFFE
    cyc(1,0,1,1,0,1,16'h0100, pk(2'd2,0,0,0,1,0,16'h0042,16'd3));
    cyc(1,0,0,1,0,1,16'hFFFF, pk(2'd2,0,0,0,1,0,16'h0042,16'd3));
    // halt/load outside ISSUE are ignored; PC wraps to 0
    cyc(1,0,0,0,1,1,16'h1234, pk(2'd0,1,1,0,0,0,16'hFFFE,16'd3));
    cyc(1,0,0,1,1,1,16'h1234, pk(2'd1,1,1,1,0,0,16'hFFFF,16'd3));
    // halt without exec_done is ignored, then halt wins over load_pc
    cyc(1,0,0,0,1,1,16'h1234, pk(2'd2,0,0,0,1,0,16'h0000,16'd4));
    cyc(1,0,0,1,1,1,16'h0200, pk(2'd2,0,0,0,1,0,16'h0000,16'd4));
    for (int i = 0; i < 20; i++) begin
      cyc(1,0,logic'(i % 2),1,0,1,16'h0300, pk(2'd3,0,0,0,0,1,16'h0000,16'd4));
    end
    // reset leaves HALTED
    cyc(0,0,0,0,0,0,16'h0000, pk(2'd0,1,1,0,0,0,16'h0000,16'd0));
    cyc(1,0,0,0,0,0,16'h0000, pk(2'd0,1,1,0,0,0,16'h0000,16'd0));
    cyc(1,0,0,0,0,0,16'h0000, pk(2'd1,1,1,1,0,0,16'h0001,16'd0));
    cyc(1,0,0,0,0,0,16'h0000, pk(2'd2,0,0,0,1,0,16'h0002,16'd1));
    cyc(1,0,0,1,0,0,16'h0000, pk(2'd2,0,0,0,1,0,16'h0002,16'd1));
    cyc(1,0,0,0,0,0,16'h0000, pk(2'd0,1,1,0,0,0,16'h0002,16'd1));
    // asynchronous reset between edges while in FETCH_H
    cyc(1,1,0,0,0,0,16'h0000, pk(2'd0,1,1,0,0,0,16'h0000,16'd0));
    cyc(1,0,0,0,0,0,16'h0000, pk(2'd0,1,1,0,0,0,16'h0000,16'd0));
    cyc(1,0,0,0,0,0,16'h0000, pk(2'd1,1,1,1,0,0,16'h0001,16'd0));

    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream control stage for the 16-bit instruction register (IR). The IR is loaded from byte-wide memory in two halves, selected by a low/high byte-select line.
- Owns the program counter (PC) and drives the memory read address.
- Issues the IR write strobe and low/high byte select over two fetch cycles, then holds the fetched instruction valid until the execute stage signals completion. Branches redirect the PC.

Parameters:
- ADDR_WIDTH, 16, width of PC and MemAddr.
- RESET_PC, 16'h0000, PC value after reset. Must be even.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  when high, FSM state and PC hold; strobes are forced low.
- Halt  in  1  sampled only in ISSUE with ExecDone; enters HALTED.
- ExecDone  in  1  execute stage has finished the issued instruction.
- LoadPC  in  1  branch taken; valid only together with ExecDone in ISSUE.
- NewPC  in  ADDR_WIDTH  branch target; bit 0 is ignored and forced to 0.
- MemAddr  out  ADDR_WIDTH  memory read address; equals PC (combinational).
- MemRead  out  1  memory read enable.
- IRWrite  out  1  IR write strobe.
- IRLH  out  1  IR byte select: 0 = bits 7:0, 1 = bits 15:8.
- InstrValid  out  1  IR holds a complete instruction for the decoder.
- PC  out  ADDR_WIDTH  current program counter.
- FetchCount  out  16  count of completed fetches; wraps at 16'hFFFF->0.
- Halted  out  1  sequencer is stopped.

Behaviour:
- States: FETCH_L, FETCH_H, ISSUE, HALTED. Use a 2-bit encoding.
- Reset (Reset=0, asynchronous):
  - state=FETCH_L, PC=RESET_PC, FetchCount=0.
  - All outputs derived from these values, so InstrValid=0 and Halted=0.
- Memory is combinational-read. Data for MemAddr is valid in the same cycle, and the IR captures it on the same rising edge.
- FETCH_L: MemRead=1, IRWrite=1, IRLH=0.
  - Next edge: PC<=PC+1, go to FETCH_H.
- FETCH_H: MemRead=1, IRWrite=1, IRLH=1.
  - Next edge: PC<=PC+1, FetchCount<=FetchCount+1, go to ISSUE.
- ISSUE: InstrValid=1, MemRead=0, IRWrite=0. PC points to the next instruction.
  - ExecDone=0: stay in ISSUE.
  - ExecDone=1 and Halt=1: go to HALTED. PC is unchanged, even if LoadPC=1.
  - ExecDone=1, Halt=0, LoadPC=1: PC<={NewPC[ADDR_WIDTH-1:1],1'b0}, go to FETCH_L.
  - ExecDone=1, Halt=0, LoadPC=0: go to FETCH_L.
- HALTED: Halted=1, all strobes 0, InstrValid=0. Only Reset exits this state.
- Stall=1 in any state:
  - No state, PC or FetchCount change.
  - MemRead=IRWrite=0; InstrValid keeps its state-derived value.
  - Stall has priority over ExecDone.
- Minimum instruction period: 3 cycles (FETCH_L, FETCH_H, ISSUE with ExecDone=1).
- PC arithmetic is modulo 2^ADDR_WIDTH. Fetching at the top address wraps the PC to 0 with no error.
- LoadPC or Halt outside ISSUE, or without ExecDone, is ignored.
- IRWrite and IRLH are registered-state-derived only (no input-to-output combinational path except Stall gating), so they are glitch-free at the clock edge.
- Reset asserted mid-fetch: immediate return to reset values. The partially loaded IR is never flagged valid.

Test Plan:
- Reset release with RESET_PC=0, ExecDone tied 1 -> cycles show (IRWrite,IRLH,MemAddr) = (1,0,0),(1,1,1),(0,x,2)/InstrValid=1, then (1,0,2); FetchCount increments to 1 at the end of cycle 2.
- Branch: in ISSUE, ExecDone=1, LoadPC=1, NewPC=16'h0041 -> next cycle FETCH_L with MemAddr=16'h0040 (bit 0 cleared).
- Stall=1 for 3 cycles during FETCH_H -> IRWrite=0, PC frozen; after release IRLH=1 is re-issued at the same address, and FetchCount increments exactly once.
- Wrap: LoadPC to 16'hFFFE -> fetch addresses FFFE, FFFF; PC reads 0000 in ISSUE.
- Halt with ExecDone=1 and LoadPC=1 in ISSUE -> Halted=1, PC unchanged, no further IRWrite for 20 cycles; Reset low returns to FETCH_L at RESET_PC.
- Async reset asserted between clock edges during FETCH_H -> outputs change before the next edge; PC=RESET_PC, InstrValid=0, FetchCount=0.
